// File: rtl/bf16_subtractor_seq.sv
// rtl/bf16_subtractor_seq.sv - multi-cycle bfloat16 subtractor (a - b), valid/ready in and out
// Iterative one-bit-per-cycle normalisation; truncating rounding; denormals flushed to zero.
module bf16_subtractor_seq #(
  parameter int          GUARD_BITS = 3,
  parameter logic [15:0] NAN_VALUE  = 16'h7FC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        flag_ovf,
  output logic        flag_zero
);
  localparam int          MW   = 8 + GUARD_BITS;
  localparam int          SW   = MW + 1;
  localparam logic [7:0]  MW8  = 8'(MW);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t          r_state;
  logic [15:0]     r_a;
  logic [15:0]     r_b;
  logic [MW-1:0]   r_mant_l;
  logic [MW-1:0]   r_mant_s;
  logic [SW-1:0]   r_sum;
  logic [7:0]      r_exp;
  logic            r_sign;
  logic            r_eff_sub;
  logic [15:0]     r_result;
  logic            r_flag_ovf;
  logic            r_flag_zero;
  logic            r_out_valid;

  // r_b already carries the inverted sign, so both operands are in effective-add form
  logic            w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic            w_a_larger;
  logic [7:0]      w_exp_l, w_exp_s, w_shift;
  logic [6:0]      w_frac_l, w_frac_s;
  logic            w_sign_l;
  logic [MW-1:0]   w_mant_s_full, w_mant_s_al;
  logic            w_special, w_special_zero;
  logic [15:0]     w_special_res;
  logic [SW-1:0]   w_sum;

  assign w_zero_a = (r_a[14:7] == 8'h00);
  assign w_zero_b = (r_b[14:7] == 8'h00);
  assign w_inf_a  = (r_a[14:7] == 8'hFF) && (r_a[6:0] == 7'h00);
  assign w_inf_b  = (r_b[14:7] == 8'hFF) && (r_b[6:0] == 7'h00);
  assign w_nan_a  = (r_a[14:7] == 8'hFF) && (r_a[6:0] != 7'h00);
  assign w_nan_b  = (r_b[14:7] == 8'hFF) && (r_b[6:0] != 7'h00);

  assign w_a_larger    = (r_a[14:0] >= r_b[14:0]);
  assign w_exp_l       = w_a_larger ? r_a[14:7] : r_b[14:7];
  assign w_exp_s       = w_a_larger ? r_b[14:7] : r_a[14:7];
  assign w_frac_l      = w_a_larger ? r_a[6:0]  : r_b[6:0];
  assign w_frac_s      = w_a_larger ? r_b[6:0]  : r_a[6:0];
  assign w_sign_l      = w_a_larger ? r_a[15]   : r_b[15];
  assign w_shift       = w_exp_l - w_exp_s;
  assign w_mant_s_full = {1'b1, w_frac_s, {GUARD_BITS{1'b0}}};
  assign w_mant_s_al   = (w_shift >= MW8) ? '0 : (w_mant_s_full >> w_shift);

  always_comb begin
    w_special      = 1'b1;
    w_special_zero = 1'b0;
    w_special_res  = 16'h0000;
    if (w_nan_a || w_nan_b) begin
      w_special_res = NAN_VALUE;
    end else if (w_inf_a && w_inf_b) begin
      w_special_res = (r_a[15] == r_b[15]) ? r_a : NAN_VALUE;
    end else if (w_inf_a) begin
      w_special_res = r_a;
    end else if (w_inf_b) begin
      w_special_res = r_b;
    end else if (w_zero_a && w_zero_b) begin
      w_special_zero = 1'b1;
    end else if (w_zero_a) begin
      w_special_res = r_b;
    end else if (w_zero_b) begin
      w_special_res = r_a;
    end else begin
      w_special = 1'b0;
    end
  end

  assign w_sum = r_eff_sub ? ({1'b0, r_mant_l} - {1'b0, r_mant_s})
                           : ({1'b0, r_mant_l} + {1'b0, r_mant_s});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_mant_l    <= '0;
      r_mant_s    <= '0;
      r_sum       <= '0;
      r_exp       <= 8'h00;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_result    <= 16'h0000;
      r_flag_ovf  <= 1'b0;
      r_flag_zero <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a         <= a;
            r_b         <= {~b[15], b[14:0]};
            r_flag_ovf  <= 1'b0;
            r_flag_zero <= 1'b0;
            r_state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_special) begin
            r_result    <= w_special_res;
            r_flag_zero <= w_special_zero;
            r_state     <= S_DONE;
          end else begin
            r_mant_l  <= {1'b1, w_frac_l, {GUARD_BITS{1'b0}}};
            r_mant_s  <= w_mant_s_al;
            r_exp     <= w_exp_l;
            r_sign    <= w_sign_l;
            r_eff_sub <= r_a[15] ^ r_b[15];
            r_state   <= S_ADD;
          end
        end
        S_ADD: begin
          if (w_sum == '0) begin
            r_result    <= 16'h0000;
            r_flag_zero <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_sum   <= w_sum;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_sum[SW-1]) begin
            // carry out: one right shift suffices, fraction sits one bit higher
            if (r_exp == 8'hFE) begin
              r_result   <= {r_sign, 8'hFF, 7'h00};
              r_flag_ovf <= 1'b1;
            end else begin
              r_result <= {r_sign, r_exp + 8'd1, r_sum[MW-1 -: 7]};
            end
            r_state <= S_DONE;
          end else if (r_sum[MW-1]) begin
            r_result <= {r_sign, r_exp, r_sum[MW-2 -: 7]};
            r_state  <= S_DONE;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 8'd1;
            if (r_exp == 8'd1) begin
              r_result    <= 16'h0000;
              r_flag_zero <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_ovf  = r_flag_ovf;
  assign flag_zero = r_flag_zero;

endmodule
